alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//  Parametrised, handshaked successor of the 8-bit toy ALU wrapper. It accepts one operation per
//  valid/ready transfer, registers the result and NZCV flags, and holds them until consumed.
//  Add/sub/logic ops take one cycle. Shifts use an iterative 1-bit/cycle datapath.
//  Sits between the lab operand source and any result consumer.
// PARAMETERS
//  WIDTH   8   operand/result width; power of two, >= 4
//  SHW     $clog2(WIDTH)   derived localparam; shift amount = in_b[SHW-1:0]
// PORTS
//  clk        in   1      rising-edge clock; only clock
//  rst        in   1      reset, synchronous, active-high
//  in_valid   in   1      operation request
//  in_ready   out  1      block can accept an operation (state IDLE and !rst)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B / shift amount
//  control    in   3      000 add, 001 sub, 010 and, 011 or, 100 xor, 101 asr, 110 lsr, 111 reserved
//  out_valid  out  1      result/flags valid (state DONE)
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  flags      out  4      registered {N,Z,C,V}
//  busy       out  1      high in SHIFT state
//  acc_sel    in   1      only with ALU_ACC_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state<=IDLE; result, flags, out_valid, busy <= 0; shift counter <= 0.
//    Reset in any state, including mid-shift or DONE with a pending result, discards the operation.
//  - Transfers: input fires on in_valid&&in_ready; output fires on out_valid&&out_ready.
//  - FSM IDLE: in_ready=1. On fire, latch operands and control.
//      add/sub/logic/reserved -> compute, load result/flags, go DONE.
//      asr/lsr with amount 0 -> result=in_a, go DONE.
//      asr/lsr with amount k>0 -> load in_a and counter k, go SHIFT.
//  - FSM SHIFT: each cycle shift 1 bit (asr replicates MSB, lsr fills 0) and decrement the counter.
//    When the counter reaches 0, load result/flags and go DONE. in_valid is ignored.
//  - FSM DONE: out_valid=1; result/flags stable until out_ready. On fire go IDLE.
//    There is no accept in the same cycle, so peak rate is 1 op / 2 cycles.
//  - Latency (input fire -> out_valid high): 1 cycle for non-shift ops or shift by 0; 1+k cycles for shift by k.
//  - Arithmetic is modulo 2^WIDTH.
//      add: C = carry-out; V = signed overflow.
//      sub: a-b; C = borrow (a<b unsigned); V = signed overflow.
//      logic/shift: C=0, V=0.
//  - N = result[WIDTH-1]; Z = (result==0) for all ops.
//  - Reserved control 111: result=0, flags={0,1,0,0}; still completes via DONE.
//  - in_b bits above SHW are ignored for shifts.
// CONFIGURATION
//  ALU_ACC_EN defined: acc_sel port exists, plus an internal WIDTH-bit accumulator (reset 0).
//    The accumulator is loaded with result on every output fire.
//    If acc_sel=1 at input fire, the accumulator replaces in_a as operand A.
//  ALU_ACC_EN undefined: no acc_sel port, no accumulator; operand A is always in_a.
// TESTING
//  1. WIDTH=8, add 0x7F+0x01, out_ready=1 -> out_valid 1 cycle after fire, result 0x80, flags N1 Z0 C0 V1.
//  2. sub 0x05-0x07 -> result 0xFE, flags N1 Z0 C1 V0. xor 0xAA^0xAA -> 0x00, Z=1.
//  3. asr 0x80 by in_b=3 -> busy 3 cycles, out_valid 4 cycles after fire, result 0xF0.
//     lsr 0x80 by 3 -> 0x10.
//  4. Hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, new in_valid ignored.
//  5. rst=1 during SHIFT of a shift by 7 -> next cycle IDLE, out_valid=0, result=0, in_ready=1 after rst drops.
//  6. ALU_ACC_EN: add 3+4 (consumed), then acc_sel=1 with in_b=5 -> result 0x0C;
//     without the macro, the same sequence gives in_a+5.

Source files
------------

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with registered result and NZCV flags.
// Add, sub and logic ops finish in one cycle. Shifts run on an iterative
// datapath that moves one bit per cycle.
// Optional build macro ALU_ACC_EN adds the acc_sel port and an internal
// accumulator. When acc_sel is set at input fire, the accumulator replaces
// in_a as operand A.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for an operation; in_ready high
// SHIFT  | iterative shift in progress, one bit per cycle; busy high
// DONE   | result/flags valid and held until out_ready

module alu_seq_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             busy
`ifdef ALU_ACC_EN
   ,
   input  logic             acc_sel
`endif
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_ASR = 3'b101;
   localparam logic [2:0] OP_LSR = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sh_reg;
   logic [SHW-1:0]   sh_cnt;
   logic             sh_asr;

   logic             in_fire;
   logic             out_fire;
   logic [WIDTH-1:0] op_a;
   logic [SHW-1:0]   sh_amt;
   logic             is_shift;
   logic [WIDTH:0]   add_full;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic [WIDTH-1:0] sh_next;

`ifdef ALU_ACC_EN
   logic [WIDTH-1:0] acc;
`endif

   // Acceptance is gated by reset so nothing is taken while reset is asserted.
   assign in_ready = (state == S_IDLE) && !rst;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

`ifdef ALU_ACC_EN
   assign op_a = acc_sel ? acc : in_a;
`else
   assign op_a = in_a;
`endif

   // Upper bits of in_b are ignored for shifts.
   assign sh_amt   = in_b[SHW-1:0];
   assign is_shift = (control == OP_ASR) || (control == OP_LSR);

   // Single-cycle datapath; a shift by zero passes operand A through.
   always_comb begin
      add_full = {1'b0, op_a} + {1'b0, in_b};
      diff     = op_a - in_b;
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      case (control)
         OP_ADD: begin
            alu_res = add_full[WIDTH-1:0];
            alu_c   = add_full[WIDTH];
            alu_v   = (op_a[WIDTH-1] == in_b[WIDTH-1]) &&
                      (add_full[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_c   = (op_a < in_b);
            alu_v   = (op_a[WIDTH-1] != in_b[WIDTH-1]) &&
                      (diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_AND:  alu_res = op_a & in_b;
         OP_OR:   alu_res = op_a | in_b;
         OP_XOR:  alu_res = op_a ^ in_b;
         OP_ASR:  alu_res = op_a;
         OP_LSR:  alu_res = op_a;
         default: alu_res = '0;
      endcase
   end

   // One-bit shift step: asr replicates the sign bit, lsr fills with zero.
   always_comb begin
      sh_next = {sh_asr & sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
   end

   // Sequencer FSM with registered result, flags and handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         result    <= '0;
         flags     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sh_reg    <= '0;
         sh_cnt    <= '0;
         sh_asr    <= 1'b0;
`ifdef ALU_ACC_EN
         acc       <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_fire) begin
                  if (is_shift && (sh_amt != '0)) begin
                     sh_reg <= op_a;
                     sh_cnt <= sh_amt;
                     sh_asr <= (control == OP_ASR);
                     busy   <= 1'b1;
                     state  <= S_SHIFT;
                  end else begin
                     result    <= alu_res;
                     flags     <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end
               end
            end
            S_SHIFT: begin
               sh_reg <= sh_next;
               sh_cnt <= sh_cnt - SHW'(1);
               // Last step: publish the shifted value directly so latency is 1+k.
               if (sh_cnt == SHW'(1)) begin
                  result    <= sh_next;
                  flags     <= {sh_next[WIDTH-1], (sh_next == '0), 2'b00};
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_fire) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
`ifdef ALU_ACC_EN
                  acc       <= result;
`endif
               end
            end
            default: begin
               busy      <= 1'b0;
               out_valid <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Testbench for alu_seq_unit (WIDTH=8): directed vector table, randomized
// operations against a plain-arithmetic reference model, and hand-written
// reset / back-pressure / accumulator sequences.

module tb_alu_seq_unit;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [2:0] control;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic [3:0] flags;
   logic       busy;
`ifdef ALU_ACC_EN
   logic       acc_sel;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   alu_seq_unit #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .control   (control),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .busy      (busy)
`ifdef ALU_ACC_EN
      ,
      .acc_sel   (acc_sel)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] ctl;
      logic [7:0] res;
      logic [3:0] flg;
      string      name;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference model: result and {N,Z,C,V} from plain integer arithmetic.
   function automatic logic [11:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] ctl);
      int ua, ub, sa, sb, amt, r, s;
      bit c, v;
      logic [7:0] rr;
      ua = a; ub = b; sa = $signed(a); sb = $signed(b); amt = ub % 8;
      c = 0; v = 0; r = 0;
      case (ctl)
         3'd0: begin s = ua + ub; r = s % 256; c = (s > 255); s = sa + sb; v = (s > 127 || s < -128); end
         3'd1: begin s = ua - ub; r = (s + 256) % 256; c = (ua < ub); s = sa - sb; v = (s > 127 || s < -128); end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd5: r = (sa >>> amt) & 255;
         3'd6: r = ua >> amt;
         default: r = 0;
      endcase
      rr = r[7:0];
      return {rr, rr[7], (rr == 8'd0), c, v};
   endfunction

   // One full transaction: issue, measure latency and busy time, hold DONE, consume.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] ctl,
                        input logic sel, input int hold, input logic [7:0] er,
                        input logic [3:0] ef, input string nm);
      int k, lat, bcnt;
      k = (ctl == 3'd5 || ctl == 3'd6) ? int'(b[2:0]) : 0;
      @(negedge clk);
      in_a = a; in_b = b; control = ctl; in_valid = 1'b1;
`ifdef ALU_ACC_EN
      acc_sel = sel;
`else
      if (sel) in_a = a;
`endif
      check({nm, " in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_a = 8'($urandom); in_b = 8'($urandom); control = 3'($urandom);
`ifdef ALU_ACC_EN
      acc_sel = 1'b0;
`endif
      lat = 1; bcnt = 0;
      while (!out_valid && lat < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      check({nm, " latency"}, lat, 1 + k);
      check({nm, " busy cycles"}, bcnt, k);
      check({nm, " result"}, result, er);
      check({nm, " flags"}, flags, ef);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); control = 3'($urandom);
         @(negedge clk);
         check({nm, " hold {out_valid,in_ready,result,flags}"},
               {out_valid, in_ready, result, flags}, {1'b1, 1'b0, er, ef});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({nm, " consumed {out_valid,in_ready}"}, {out_valid, in_ready}, 2'b01);
   endtask

   vec_t vecs[14];

   initial begin
      logic [11:0] m;
      logic [7:0]  ra, rb;
      logic [2:0]  rc;
      int          cyc;

      vecs[0]  = '{8'h7F, 8'h01, 3'd0, 8'h80, 4'b1001, "add 7f+01"};
      vecs[1]  = '{8'h05, 8'h07, 3'd1, 8'hFE, 4'b1010, "sub 05-07"};
      vecs[2]  = '{8'hAA, 8'hAA, 3'd4, 8'h00, 4'b0100, "xor aa^aa"};
      vecs[3]  = '{8'h80, 8'h03, 3'd5, 8'hF0, 4'b1000, "asr 80>>3"};
      vecs[4]  = '{8'h80, 8'h03, 3'd6, 8'h10, 4'b0000, "lsr 80>>3"};
      vecs[5]  = '{8'hFF, 8'h01, 3'd0, 8'h00, 4'b0110, "add ff+01"};
      vecs[6]  = '{8'h80, 8'h01, 3'd1, 8'h7F, 4'b0001, "sub 80-01"};
      vecs[7]  = '{8'hF0, 8'h3C, 3'd2, 8'h30, 4'b0000, "and"};
      vecs[8]  = '{8'h0F, 8'h80, 3'd3, 8'h8F, 4'b1000, "or"};
      vecs[9]  = '{8'h7F, 8'h00, 3'd5, 8'h7F, 4'b0000, "asr by 0"};
      vecs[10] = '{8'h81, 8'h0F, 3'd6, 8'h01, 4'b0000, "lsr by 7 upper b ignored"};
      vecs[11] = '{8'h80, 8'h07, 3'd5, 8'hFF, 4'b1000, "asr 80>>7"};
      vecs[12] = '{8'h12, 8'h34, 3'd7, 8'h00, 4'b0100, "reserved"};
      vecs[13] = '{8'h33, 8'h33, 3'd1, 8'h00, 4'b0100, "sub equal"};

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; control = '0; out_ready = 1'b0;
`ifdef ALU_ACC_EN
      acc_sel = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset state", {out_valid, busy, in_ready, result, flags}, '0);
      rst = 1'b0;
      #1;
      check("in_ready after reset", in_ready, 1);

      foreach (vecs[i])
         do_op(vecs[i].a, vecs[i].b, vecs[i].ctl, 1'b0, (i == 0) ? 5 : (i % 3),
               vecs[i].res, vecs[i].flg, vecs[i].name);

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 3'($urandom_range(0, 7));
         m = ref_op(ra, rb, rc);
         do_op(ra, rb, rc, 1'b0, $urandom_range(0, 2), m[11:4], m[3:0], "random");
      end

      // Reset in the middle of a shift by 7 discards it.
      do_op(8'h10, 8'h05, 3'd0, 1'b0, 0, 8'h15, 4'b0000, "pre-reset add");
      @(negedge clk);
      in_a = 8'hFF; in_b = 8'h07; control = 3'd6; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("mid-shift busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("reset mid-shift {out_valid,busy,in_ready,result,flags}",
            {out_valid, busy, in_ready, result, flags}, '0);
      rst = 1'b0;
      #1;
      check("in_ready after mid-shift reset", in_ready, 1);
      cyc = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid || busy) cyc++;
      end
      check("no stale result after reset", cyc, 0);

      // Reset while DONE holds a pending result.
      @(negedge clk);
      in_a = 8'h01; in_b = 8'h01; control = 3'd0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("pending before reset", {out_valid, result}, {1'b1, 8'h02});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("reset in DONE {out_valid,result,flags}", {out_valid, result, flags}, '0);

      // Accumulator operand selection.
      do_op(8'h03, 8'h04, 3'd0, 1'b0, 0, 8'h07, 4'b0000, "acc load 3+4");
`ifdef ALU_ACC_EN
      do_op(8'h20, 8'h05, 3'd0, 1'b1, 0, 8'h0C, 4'b0000, "acc_sel add");
`else
      do_op(8'h20, 8'h05, 3'd0, 1'b1, 0, 8'h25, 4'b0000, "acc_sel add");
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
